ws_ctrl: RTL and testbench
==========================

WS_CTRL -- requirements
Module: ws_ctrl

Interface
REQ-001 Parameters: col=8 (weight rows per kij), len_kij=9, len_nij=36 (input pixels, 6x6), len_onij=16 (output pixels, 4x4), xw_base=8'h80 (weight base address in XMEM).
REQ-002 Ports: clk  in  1  single clock, all logic on posedge.
REQ-003 Ports: reset  in  1  asynchronous, active-high.
REQ-004 Ports: start  in  1  one-cycle pulse that begins a full layer run.
REQ-005 Ports: l0_ready  in  1  L0 can accept a row.
REQ-006 Ports: ofifo_valid  in  1  OFIFO holds a complete psum row.
REQ-007 Ports: load, execute, mode  out  1 each  array instruction bits.
REQ-008 Ports: CEN0_xmem, WEN0_xmem  out  1 each, active-low; A0_xmem  out  8.
REQ-009 Ports: CEN_pmem, WEN_pmem  out  1 each, active-low; A_pmem  out  9.
REQ-010 Ports: acc, psum_bypass, ofifo_rd, max_pool_en  out  1 each.
REQ-011 Ports: busy, done (1-cycle pulse), psum_ovf (sticky)  out  1 each; oc_idx  out  4  output pixel being accumulated.

Function
REQ-012 All outputs SHALL be registered; FSM states: IDLE, LOAD, EXEC, NEXT, WAIT_PSUM, ACC, ACC_GAP, DONE.
REQ-013 IDLE: start -> LOAD with kij=0, t=0, busy=1; start while busy SHALL be ignored.
REQ-014 LOAD: cycle with l0_ready=1 -> CEN0=0, WEN0=1, A0=xw_base+kij*8+t, load=1, t++; l0_ready=0 -> CEN0=1, A0 held, t held; after t=col-1 issued -> EXEC, t=0.
REQ-015 EXEC: same l0_ready gating, A0=t (0..35), execute=1, load=0; after t=len_nij-1 issued -> NEXT.
REQ-016 NEXT: one cycle, CEN0=1, load=execute=0, mode=1; kij<8 -> LOAD with kij++, else -> WAIT_PSUM.
REQ-017 PMEM writer runs concurrently from first LOAD cycle until WAIT_PSUM exits: each cycle with ofifo_valid=1 and wcnt<324 -> ofifo_rd=1, CEN_pmem=0, WEN_pmem=0, A_pmem=wcnt, wcnt++.
REQ-018 ofifo_valid=1 with wcnt=324 -> no write, no ofifo_rd, psum_ovf set until reset.
REQ-019 psum_bypass=1 from first LOAD through WAIT_PSUM, else 0.
REQ-020 WAIT_PSUM: wcnt=324 -> ACC with oc=0, k=0.
REQ-021 ACC: acc=1, CEN_pmem=0, WEN_pmem=1, A_pmem=k*36 + (oc/4)*6 + oc%4 + 6*(k/3) + k%3, k++; after k=8 -> ACC_GAP.
REQ-022 ACC_GAP: one cycle acc=0, CEN_pmem=1; oc<15 -> ACC with oc++, k=0; oc=15 -> DONE.
REQ-023 oc_idx SHALL equal oc in ACC/ACC_GAP, 0 otherwise.
REQ-024 DONE: done=1 for one cycle, busy=0 -> IDLE; wcnt, kij, oc cleared.
REQ-025 Address arithmetic: A_pmem max 323 fits 9 bits; A0 max 8'hC7; no wrap permitted.

Reset
REQ-026 reset SHALL force IDLE immediately, including mid-run; outputs: CEN0/WEN0/CEN_pmem/WEN_pmem=1, all addresses=0, load/execute/mode/acc/psum_bypass/ofifo_rd/max_pool_en/busy/done/psum_ovf=0, oc_idx=0.
REQ-027 After reset deasserts, no activity until a new start pulse.

Configuration
REQ-028 Macro WS_CTRL_MAX_POOL_EN: defined -> max_pool_en=1 during ACC and ACC_GAP, 0 otherwise; undefined -> max_pool_en tied 0, all else identical.

Verification
REQ-029 l0_ready=1, ofifo_valid driven by core model; start -> 9x(8 loads A0=0x80+kij*8.., 36 executes A0=0..35), 324 PMEM writes A_pmem=0..323, done after 16x10 ACC/GAP cycles.
REQ-030 l0_ready toggled every other cycle during LOAD kij=3 -> CEN0=1 on low cycles, A0 sequence 0x98..0x9F without gaps or repeats.
REQ-031 ACC phase, oc=5, k=4 -> A_pmem=4*36+7+7=158; oc=15, k=8 -> A_pmem=288+21+14=323.
REQ-032 Extra ofifo_valid cycle after 324th write -> psum_ovf=1, no PMEM write, sticky until reset.
REQ-033 reset asserted during EXEC kij=2 -> same-cycle async return to reset outputs; subsequent start replays from kij=0.
REQ-034 WS_CTRL_MAX_POOL_EN built/unbuilt -> max_pool_en high exactly 160 cycles / never.

Source files
------------

// File: rtl/ws_ctrl.sv
// Weight-stationary layer controller: streams weights/activations into L0, drains psums to PMEM, then accumulates.
// Optional build macro WS_CTRL_MAX_POOL_EN drives max_pool_en during the accumulate phase.
module ws_ctrl #(
  parameter int unsigned COL      = 8,
  parameter int unsigned LEN_KIJ  = 9,
  parameter int unsigned LEN_NIJ  = 36,
  parameter int unsigned LEN_ONIJ = 16,
  parameter logic [7:0]  XW_BASE  = 8'h80
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       l0_ready,
  input  logic       ofifo_valid,
  output logic       load,
  output logic       execute,
  output logic       mode,
  output logic       CEN0_xmem,
  output logic       WEN0_xmem,
  output logic [7:0] A0_xmem,
  output logic       CEN_pmem,
  output logic       WEN_pmem,
  output logic [8:0] A_pmem,
  output logic       acc,
  output logic       psum_bypass,
  output logic       ofifo_rd,
  output logic       max_pool_en,
  output logic       busy,
  output logic       done,
  output logic       psum_ovf,
  output logic [3:0] oc_idx
);

  localparam int unsigned PSUM_N = LEN_KIJ * LEN_NIJ;
  localparam int unsigned IN_W   = 6;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_EXEC, S_NEXT, S_WAIT_PSUM, S_ACC, S_ACC_GAP, S_DONE
  } state_t;

  state_t     state_q, state_n;
  logic [3:0] kij_q, kij_n, oc_q, oc_n, k_q, k_n;
  logic [5:0] t_q, t_n;
  logic [8:0] wcnt_q, wcnt_n;
  logic       win;

  logic       load_n, execute_n, mode_n, cen0_n, wen0_n, cen_p_n, wen_p_n;
  logic       acc_n, bypass_n, rd_n, mp_n, busy_n, done_n, ovf_n;
  logic [7:0] a0_n;
  logic [8:0] a_p_n;
  logic [3:0] oc_idx_n;

  assign win = (state_q == S_LOAD) || (state_q == S_EXEC) ||
               (state_q == S_NEXT) || (state_q == S_WAIT_PSUM);

  // State and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      kij_q       <= '0;
      t_q         <= '0;
      wcnt_q      <= '0;
      oc_q        <= '0;
      k_q         <= '0;
      load        <= 1'b0;
      execute     <= 1'b0;
      mode        <= 1'b0;
      CEN0_xmem   <= 1'b1;
      WEN0_xmem   <= 1'b1;
      A0_xmem     <= '0;
      CEN_pmem    <= 1'b1;
      WEN_pmem    <= 1'b1;
      A_pmem      <= '0;
      acc         <= 1'b0;
      psum_bypass <= 1'b0;
      ofifo_rd    <= 1'b0;
      max_pool_en <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      psum_ovf    <= 1'b0;
      oc_idx      <= '0;
    end else begin
      state_q     <= state_n;
      kij_q       <= kij_n;
      t_q         <= t_n;
      wcnt_q      <= wcnt_n;
      oc_q        <= oc_n;
      k_q         <= k_n;
      load        <= load_n;
      execute     <= execute_n;
      mode        <= mode_n;
      CEN0_xmem   <= cen0_n;
      WEN0_xmem   <= wen0_n;
      A0_xmem     <= a0_n;
      CEN_pmem    <= cen_p_n;
      WEN_pmem    <= wen_p_n;
      A_pmem      <= a_p_n;
      acc         <= acc_n;
      psum_bypass <= bypass_n;
      ofifo_rd    <= rd_n;
      max_pool_en <= mp_n;
      busy        <= busy_n;
      done        <= done_n;
      psum_ovf    <= ovf_n;
      oc_idx      <= oc_idx_n;
    end
  end

  // Next state, counters and next output values
  always_comb begin
    state_n   = state_q;
    kij_n     = kij_q;
    t_n       = t_q;
    wcnt_n    = wcnt_q;
    oc_n      = oc_q;
    k_n       = k_q;
    load_n    = 1'b0;
    execute_n = 1'b0;
    mode_n    = 1'b0;
    cen0_n    = 1'b1;
    wen0_n    = 1'b1;
    a0_n      = A0_xmem;
    cen_p_n   = 1'b1;
    wen_p_n   = 1'b1;
    a_p_n     = A_pmem;
    acc_n     = 1'b0;
    bypass_n  = 1'b0;
    rd_n      = 1'b0;
    busy_n    = busy;
    done_n    = 1'b0;
    ovf_n     = psum_ovf;
    oc_idx_n  = '0;

    // PMEM writer runs alongside the load/execute sweep
    if (win) begin
      bypass_n = 1'b1;
      if (ofifo_valid) begin
        if (wcnt_q < 9'(PSUM_N)) begin
          rd_n    = 1'b1;
          cen_p_n = 1'b0;
          wen_p_n = 1'b0;
          a_p_n   = wcnt_q;
          wcnt_n  = wcnt_q + 9'd1;
        end else begin
          ovf_n = 1'b1;
        end
      end
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_n = S_LOAD;
          kij_n   = '0;
          t_n     = '0;
          busy_n  = 1'b1;
        end
      end
      S_LOAD: begin
        if (l0_ready) begin
          cen0_n = 1'b0;
          load_n = 1'b1;
          a0_n   = XW_BASE + 8'(kij_q) * 8'(COL) + 8'(t_q);
          if (t_q == 6'(COL - 1)) begin
            state_n = S_EXEC;
            t_n     = '0;
          end else begin
            t_n = t_q + 6'd1;
          end
        end
      end
      S_EXEC: begin
        if (l0_ready) begin
          cen0_n    = 1'b0;
          execute_n = 1'b1;
          a0_n      = 8'(t_q);
          if (t_q == 6'(LEN_NIJ - 1)) begin
            state_n = S_NEXT;
            t_n     = '0;
          end else begin
            t_n = t_q + 6'd1;
          end
        end
      end
      S_NEXT: begin
        mode_n = 1'b1;
        if (kij_q < 4'(LEN_KIJ - 1)) begin
          state_n = S_LOAD;
          kij_n   = kij_q + 4'd1;
        end else begin
          state_n = S_WAIT_PSUM;
        end
      end
      S_WAIT_PSUM: begin
        if (wcnt_q == 9'(PSUM_N)) begin
          state_n = S_ACC;
          oc_n    = '0;
          k_n     = '0;
        end
      end
      S_ACC: begin
        acc_n    = 1'b1;
        cen_p_n  = 1'b0;
        wen_p_n  = 1'b1;
        oc_idx_n = oc_q;
        // psum of kernel offset k at the input pixel under output pixel oc (4-wide output, 6-wide input)
        a_p_n    = 9'(k_q) * 9'(LEN_NIJ) + 9'(oc_q[3:2]) * 9'(IN_W) + 9'(oc_q[1:0])
                 + 9'(k_q / 4'd3) * 9'(IN_W) + 9'(k_q % 4'd3);
        if (k_q == 4'(LEN_KIJ - 1)) begin
          state_n = S_ACC_GAP;
          k_n     = '0;
        end else begin
          k_n = k_q + 4'd1;
        end
      end
      S_ACC_GAP: begin
        oc_idx_n = oc_q;
        if (oc_q < 4'(LEN_ONIJ - 1)) begin
          state_n = S_ACC;
          oc_n    = oc_q + 4'd1;
          k_n     = '0;
        end else begin
          state_n = S_DONE;
        end
      end
      S_DONE: begin
        done_n  = 1'b1;
        busy_n  = 1'b0;
        state_n = S_IDLE;
        wcnt_n  = '0;
        kij_n   = '0;
        oc_n    = '0;
      end
      default: state_n = S_IDLE;
    endcase
  end

`ifdef WS_CTRL_MAX_POOL_EN
  assign mp_n = (state_q == S_ACC) || (state_q == S_ACC_GAP);
`else
  assign mp_n = 1'b0;
`endif

endmodule

// File: tb/tb_ws_ctrl.sv
// Randomized directed bench for ws_ctrl against an index-arithmetic reference of the layer schedule.
module tb_ws_ctrl;

  logic       clk = 1'b0;
  logic       reset, start, l0_ready, ofifo_valid;
  logic       load, execute, mode, CEN0_xmem, WEN0_xmem, CEN_pmem, WEN_pmem;
  logic       acc, psum_bypass, ofifo_rd, max_pool_en, busy, done, psum_ovf;
  logic [7:0] A0_xmem;
  logic [8:0] A_pmem;
  logic [3:0] oc_idx;

  int errors = 0;
  int checks = 0;

`ifdef WS_CTRL_MAX_POOL_EN
  localparam int MP_EXP = 160;
`else
  localparam int MP_EXP = 0;
`endif

  ws_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .l0_ready(l0_ready), .ofifo_valid(ofifo_valid),
    .load(load), .execute(execute), .mode(mode),
    .CEN0_xmem(CEN0_xmem), .WEN0_xmem(WEN0_xmem), .A0_xmem(A0_xmem),
    .CEN_pmem(CEN_pmem), .WEN_pmem(WEN_pmem), .A_pmem(A_pmem),
    .acc(acc), .psum_bypass(psum_bypass), .ofifo_rd(ofifo_rd), .max_pool_en(max_pool_en),
    .busy(busy), .done(done), .psum_ovf(psum_ovf), .oc_idx(oc_idx)
  );

  always #5 clk = ~clk;

  // Observed transactions, sampled just after each rising edge
  logic [9:0]  xq[$];
  logic [8:0]  wq[$];
  logic [13:0] rq[$];
  int mp_cnt, mode_cnt, done_cnt, exec_cnt, act_cnt, viol;
  bit mon_en = 1'b0;

  always @(posedge clk) begin
    #1;
    if (mon_en) begin
      if (!CEN0_xmem) xq.push_back({load, execute, A0_xmem});
      if (!CEN_pmem && !WEN_pmem) wq.push_back(A_pmem);
      if (!CEN_pmem && WEN_pmem) rq.push_back({acc, oc_idx, A_pmem});
      if (ofifo_rd != (!CEN_pmem && !WEN_pmem)) viol++;
      if (!CEN_pmem && !WEN_pmem && !psum_bypass) viol++;
      if (!l0_ready && !CEN0_xmem) viol++;
      if (!WEN0_xmem) viol++;
      mp_cnt   += int'(max_pool_en);
      mode_cnt += int'(mode);
      done_cnt += int'(done);
      exec_cnt += int'(execute && !CEN0_xmem);
      act_cnt  += int'(busy || !CEN0_xmem || !CEN_pmem);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    xq.delete(); wq.delete(); rq.delete();
    mp_cnt = 0; mode_cnt = 0; done_cnt = 0; exec_cnt = 0; act_cnt = 0; viol = 0;
  endtask

  int sent;

  // One cycle of core-side stimulus; l0m: 0 always ready, 1 toggle, 2 random; vm: 0 eager, 1 random
  task automatic drive_cycle(input int l0m, input int vm, input int target);
    @(negedge clk);
    start = 1'b0;
    case (l0m)
      0: l0_ready = 1'b1;
      1: l0_ready = ~l0_ready;
      default: l0_ready = 1'($urandom_range(0, 1));
    endcase
    ofifo_valid = 1'b0;
    if (busy && sent < target && (vm == 0 || $urandom_range(0, 1) == 1)) begin
      ofifo_valid = 1'b1;
      sent++;
    end
  endtask

  task automatic kick();
    clear_mon();
    sent = 0;
    mon_en = 1'b1;
    @(negedge clk);
    start = 1'b1;
  endtask

  task automatic run_layer(input int l0m, input int vm, input int target);
    bit fin;
    kick();
    fin = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      drive_cycle(l0m, vm, target);
      if (done_cnt > 0) begin
        fin = 1'b1;
        break;
      end
    end
    l0_ready = 1'b1;
    ofifo_valid = 1'b0;
    check("run_completes", fin, 1);
    repeat (3) @(negedge clk);
  endtask

  // Reference: per kij, COL weight rows at base+kij*8 then every input pixel; psum reads index conv windows
  task automatic check_run(input bit exp_ovf);
    logic [9:0]  ex;
    logic [13:0] er;
    int i, row, col;
    check("done_pulses", done_cnt, 1);
    check("busy_after", busy, 0);
    check("xmem_count", xq.size(), 9 * (8 + 36));
    i = 0;
    for (int kij = 0; kij < 9; kij++) begin
      for (int t = 0; t < 44; t++) begin
        if (t < 8) ex = {2'b10, 8'(128 + kij * 8 + t)};
        else       ex = {2'b01, 8'(t - 8)};
        if (i < xq.size()) check($sformatf("xmem[%0d]", i), xq[i], ex);
        i++;
      end
    end
    check("pmem_writes", wq.size(), 324);
    for (int n = 0; n < wq.size() && n < 324; n++) check($sformatf("wr[%0d]", n), wq[n], n);
    check("pmem_reads", rq.size(), 144);
    i = 0;
    for (int oc = 0; oc < 16; oc++) begin
      for (int k = 0; k < 9; k++) begin
        row = oc / 4 + k / 3;
        col = oc % 4 + k % 3;
        er  = {1'b1, 4'(oc), 9'(k * 36 + row * 6 + col)};
        if (i < rq.size()) check($sformatf("rd[%0d]", i), rq[i], er);
        i++;
      end
    end
    if (rq.size() == 144) begin
      check("rd_oc5_k4", rq[5 * 9 + 4][8:0], 158);
      check("rd_oc15_k8", rq[15 * 9 + 8][8:0], 323);
    end
    check("mode_cycles", mode_cnt, 9);
    check("max_pool_cycles", mp_cnt, MP_EXP);
    check("protocol_viol", viol, 0);
    check("psum_ovf", psum_ovf, exp_ovf);
  endtask

  function automatic logic [34:0] out_vec();
    return {CEN0_xmem, WEN0_xmem, A0_xmem, CEN_pmem, WEN_pmem, A_pmem,
            load, execute, mode, acc, psum_bypass, ofifo_rd, max_pool_en,
            busy, done, psum_ovf, oc_idx};
  endfunction

  initial begin
    logic [34:0] rst_vec;
    bit hit;
    rst_vec = {1'b1, 1'b1, 8'h00, 1'b1, 1'b1, 9'h000, 10'h000, 4'h0};
    reset = 1'b1; start = 1'b0; l0_ready = 1'b1; ofifo_valid = 1'b0;
    #1;
    check("reset_outputs", out_vec(), rst_vec);
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Idle with no start: nothing moves
    clear_mon();
    mon_en = 1'b1;
    repeat (10) @(negedge clk);
    check("idle_quiet", act_cnt, 0);

    run_layer(0, 0, 324);
    check_run(1'b0);
    run_layer(1, 1, 324);
    check_run(1'b0);
    run_layer(2, 1, 324);
    check_run(1'b0);

    // Reset in the middle of kij=2 execution, then replay from scratch
    kick();
    hit = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      drive_cycle(0, 1, 324);
      if (exec_cnt >= 36 * 2 + 10) begin
        hit = 1'b1;
        break;
      end
    end
    check("reached_kij2", hit, 1);
    reset = 1'b1;
    #1;
    check("midrun_reset_outputs", out_vec(), rst_vec);
    mon_en = 1'b0;
    ofifo_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    clear_mon();
    mon_en = 1'b1;
    repeat (20) @(negedge clk);
    check("post_reset_quiet", act_cnt, 0);
    run_layer(0, 1, 324);
    check_run(1'b0);

    // One extra psum row beyond capacity: flagged, not written, sticky
    run_layer(0, 0, 325);
    check_run(1'b1);
    repeat (5) @(negedge clk);
    check("ovf_sticky", psum_ovf, 1);
    reset = 1'b1;
    #1;
    check("ovf_cleared", psum_ovf, 0);
    @(negedge clk);
    reset = 1'b0;
    mon_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
